// File: rtl/stb_dcache_drain.sv
// Store-buffer drain engine: pops committed stores and writes them to the dcache over req/ack.
// Optional ack-timeout detection is compiled in with `define STB_DRAIN_TIMEOUT_EN.
module stb_dcache_drain #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned BYTE_SEL_WIDTH = 4,
   parameter int unsigned CNT_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stb_empty,
   input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
   input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
   input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
   output logic                      stb_rd_en,
   output logic                      rd_sel,
   output logic                      dcache_req,
   input  logic                      dcache_ack,
   output logic [ADDR_WIDTH-1:0]     dcache_addr,
   output logic [DATA_WIDTH-1:0]     dcache_wdata,
   output logic [BYTE_SEL_WIDTH-1:0] dcache_sel_byte,
   input  logic                      fence_req,
   output logic                      fence_done,
   output logic                      drain_busy,
   output logic [CNT_WIDTH-1:0]      drain_count,
   output logic                      drain_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      REQ  = 2'd2
   } state_e;

   state_e                    state_q;
   logic                      rd_en_q;
   logic                      rd_sel_q;
   logic                      req_q;
   logic                      busy_q;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [BYTE_SEL_WIDTH-1:0] sel_q;
   logic [CNT_WIDTH-1:0]      count_q;
   logic                      fence_pending_q;
   logic                      fence_done_q;

   // A zero threshold would make the timeout compare underflow.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   // Drain FSM; outputs are registered alongside the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rd_en_q  <= 1'b0;
         rd_sel_q <= 1'b0;
         req_q    <= 1'b0;
         busy_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         sel_q    <= '0;
         count_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!stb_empty) begin
                  state_q  <= READ;
                  rd_en_q  <= 1'b1;
                  rd_sel_q <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            READ: begin
               state_q  <= REQ;
               rd_en_q  <= 1'b0;
               rd_sel_q <= 1'b0;
               req_q    <= 1'b1;
               addr_q   <= stb2dcache_addr;
               wdata_q  <= stb2dcache_wdata;
               sel_q    <= stb2dcache_sel_byte;
            end
            REQ: begin
               if (dcache_ack) begin
                  count_q <= count_q + CNT_WIDTH'(1);
                  req_q   <= 1'b0;
                  if (!stb_empty) begin
                     state_q  <= READ;
                     rd_en_q  <= 1'b1;
                     rd_sel_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q  <= IDLE;
               rd_en_q  <= 1'b0;
               rd_sel_q <= 1'b0;
               req_q    <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   // Fence completes once the engine is idle with nothing left in the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         fence_pending_q <= 1'b0;
         fence_done_q    <= 1'b0;
      end else begin
         fence_done_q <= 1'b0;
         if (fence_pending_q && (state_q == IDLE) && stb_empty) begin
            fence_pending_q <= 1'b0;
            fence_done_q    <= 1'b1;
         end else if (fence_req) begin
            fence_pending_q <= 1'b1;
         end
      end
   end

`ifdef STB_DRAIN_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] tmo_cnt_q;
   logic            err_q;

   // Counts unacknowledged REQ cycles; saturates so a very late ack cannot re-arm it.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else if (state_q == READ) begin
         tmo_cnt_q <= '0;
      end else if ((state_q == REQ) && !dcache_ack && (tmo_cnt_q != TO_W'(TIMEOUT_CYCLES))) begin
         tmo_cnt_q <= tmo_cnt_q + TO_W'(1);
         if (tmo_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign drain_err = err_q;
`else
   assign drain_err = 1'b0;
`endif

   assign stb_rd_en       = rd_en_q;
   assign rd_sel          = rd_sel_q;
   assign dcache_req      = req_q;
   assign dcache_addr     = addr_q;
   assign dcache_wdata    = wdata_q;
   assign dcache_sel_byte = sel_q;
   assign fence_done      = fence_done_q;
   assign drain_busy      = busy_q;
   assign drain_count     = count_q;

endmodule
